// File: rtl/hs_clk_rx_ctrl.sv
// D-PHY RX clock lane controller: LP entry detect, termination/settle, HS clock watch.
// Define CLK_ULPS_EN to add the ULPS entry/exit path; otherwise LP-10 from STOP is an error.
module hs_clk_rx_ctrl #(
    parameter int LP_FILT      = 2,
    parameter int TERM_EN_CYC  = 3,
    parameter int SETTLE_CYC   = 20,
    parameter int CLK_MISS_CYC = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lp_dp,
    input  logic lp_dn,
    input  logic hs_clk_seen,
    output logic term_en,
    output logic hs_rx_en,
    output logic rx_clk_active,
    output logic err_seq,
    output logic ulps_active
);

    localparam int TMAX = (TERM_EN_CYC > SETTLE_CYC) ? TERM_EN_CYC : SETTLE_CYC;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam int FW   = $clog2(LP_FILT + 1);
    localparam int MW   = $clog2(CLK_MISS_CYC + 1);

    localparam logic [TW-1:0] T_TERM = TW'(TERM_EN_CYC - 1);
    localparam logic [TW-1:0] T_SET  = TW'(SETTLE_CYC - 1);
    localparam logic [FW-1:0] F_MAX  = FW'(LP_FILT);
    localparam logic [MW-1:0] M_MAX  = MW'(CLK_MISS_CYC);

    typedef enum logic [3:0] {
        ST_STOP, ST_HS_RQST, ST_BRIDGE, ST_SETTLE, ST_HS_CLK,
        ST_HS_END, ST_ERR, ST_ULPS_RQST, ST_ULPS, ST_ULPS_EXIT
    } state_t;

    state_t        st;
    logic [1:0]    raw, cand, lp_state;
    logic [FW-1:0] run_q, run_d;
    logic [TW-1:0] timer;
    logic [MW-1:0] mc_q, mc_inc;
    logic          seen_q;

    assign raw = {lp_dp, lp_dn};

    // run_d counts consecutive cycles the raw level has matched, this one included
    always_comb begin
        run_d = run_q;
        if (raw != cand)
            run_d = FW'(1);
        else if (run_q < F_MAX)
            run_d = run_q + 1'b1;
    end

    assign mc_inc = (mc_q == M_MAX) ? mc_q : mc_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand     <= 2'b11;
            run_q    <= F_MAX;
            lp_state <= 2'b11;
        end else begin
            cand  <= raw;
            run_q <= run_d;
            if (run_d >= F_MAX)
                lp_state <= raw;
        end
    end

`ifdef CLK_ULPS_EN
    logic ulps_q;
    assign ulps_active = ulps_q;
`else
    assign ulps_active = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st            <= ST_STOP;
            timer         <= '0;
            mc_q          <= '0;
            seen_q        <= 1'b0;
            term_en       <= 1'b0;
            hs_rx_en      <= 1'b0;
            rx_clk_active <= 1'b0;
            err_seq       <= 1'b0;
`ifdef CLK_ULPS_EN
            ulps_q        <= 1'b0;
`endif
        end else begin
            err_seq <= 1'b0;
            case (st)
                ST_STOP: begin
                    term_en       <= 1'b0;
                    hs_rx_en      <= 1'b0;
                    rx_clk_active <= 1'b0;
                    case (lp_state)
                        2'b01: st <= ST_HS_RQST;
                        2'b10: begin
`ifdef CLK_ULPS_EN
                            st <= ST_ULPS_RQST;
`else
                            st      <= ST_ERR;
                            err_seq <= 1'b1;
`endif
                        end
                        2'b00: begin
                            st      <= ST_ERR;
                            err_seq <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_HS_RQST: begin
                    case (lp_state)
                        2'b00: begin
                            st    <= ST_BRIDGE;
                            timer <= T_TERM;
                        end
                        2'b11: st <= ST_STOP;
                        2'b10: begin
                            st      <= ST_ERR;
                            err_seq <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_BRIDGE: begin
                    if (lp_state == 2'b11) begin
                        st <= ST_STOP;
                    end else if (lp_state != 2'b00) begin
                        st      <= ST_ERR;
                        err_seq <= 1'b1;
                    end else if (timer == '0) begin
                        st      <= ST_SETTLE;
                        timer   <= T_SET;
                        term_en <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (lp_state == 2'b11) begin
                        st      <= ST_STOP;
                        term_en <= 1'b0;
                    end else if (timer == '0) begin
                        st       <= ST_HS_CLK;
                        hs_rx_en <= 1'b1;
                        mc_q     <= '0;
                        seen_q   <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_HS_CLK: begin
                    if (lp_state == 2'b11) begin
                        st            <= ST_STOP;
                        term_en       <= 1'b0;
                        hs_rx_en      <= 1'b0;
                        rx_clk_active <= 1'b0;
                    end else if (hs_clk_seen) begin
                        mc_q          <= '0;
                        seen_q        <= 1'b1;
                        rx_clk_active <= 1'b1;
                    end else begin
                        mc_q <= mc_inc;
                        // a burst that never toggled the clock is reported as an error
                        if (mc_inc == M_MAX) begin
                            st            <= ST_HS_END;
                            term_en       <= 1'b0;
                            hs_rx_en      <= 1'b0;
                            rx_clk_active <= 1'b0;
                            err_seq       <= !seen_q;
                        end
                    end
                end
                ST_HS_END, ST_ERR: begin
                    term_en       <= 1'b0;
                    hs_rx_en      <= 1'b0;
                    rx_clk_active <= 1'b0;
                    if (lp_state == 2'b11)
                        st <= ST_STOP;
                end
`ifdef CLK_ULPS_EN
                ST_ULPS_RQST: begin
                    case (lp_state)
                        2'b00: begin
                            st      <= ST_ULPS;
                            ulps_q  <= 1'b1;
                            term_en <= 1'b0;
                        end
                        2'b11: st <= ST_STOP;
                        2'b01: begin
                            st      <= ST_ERR;
                            err_seq <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_ULPS: begin
                    if (lp_state == 2'b10)
                        st <= ST_ULPS_EXIT;
                end
                ST_ULPS_EXIT: begin
                    if (lp_state == 2'b11) begin
                        st     <= ST_STOP;
                        ulps_q <= 1'b0;
                    end
                end
`endif
                default: st <= ST_STOP;
            endcase
        end
    end

endmodule

// File: tb/tb_hs_clk_rx_ctrl.sv
// Scoreboard bench for hs_clk_rx_ctrl: expected output changes (value and edge) are queued by stimulus.
// A negedge monitor pops one entry per observed output change; build with CLK_ULPS_EN to cover ULPS.
module tb_hs_clk_rx_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic lp_dp, lp_dn, hs_clk_seen;
    logic term_en, hs_rx_en, rx_clk_active, err_seq, ulps_active;
    logic [4:0] outv;

    int edge_n = 0;
    int n_cmp  = 0;
    int n_bad  = 0;

    typedef struct {
        string      name;
        logic [4:0] vec;
        int         at;
    } exp_t;

    exp_t sb[$];
    logic [4:0] prev = 5'b0;

    hs_clk_rx_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lp_dp         (lp_dp),
        .lp_dn         (lp_dn),
        .hs_clk_seen   (hs_clk_seen),
        .term_en       (term_en),
        .hs_rx_en      (hs_rx_en),
        .rx_clk_active (rx_clk_active),
        .err_seq       (err_seq),
        .ulps_active   (ulps_active)
    );

    // {term_en, hs_rx_en, rx_clk_active, err_seq, ulps_active}
    assign outv = {term_en, hs_rx_en, rx_clk_active, err_seq, ulps_active};

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(negedge clk) begin
        exp_t x;
        if (outv !== prev) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected: got %b at edge %0d, required no change", outv, edge_n);
            end else begin
                x = sb.pop_front();
                if (outv !== x.vec || edge_n != x.at) begin
                    n_bad++;
                    $display("FAIL %s: got %b at edge %0d, required %b at edge %0d",
                             x.name, outv, edge_n, x.vec, x.at);
                end
            end
            prev = outv;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dp, input logic dn);
        lp_dp = dp;
        lp_dn = dn;
    endtask

    task automatic expect_at(input string n, input logic [4:0] v, input int at);
        sb.push_back('{n, v, at});
    endtask

    task automatic check(input string n, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", n, act, req);
        end
    endtask

    initial begin
        int e;
        lp_dp = 1'b1;
        lp_dn = 1'b1;
        hs_clk_seen = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick(3);
        check("reset_outputs", int'(outv), 0);
        rst_n = 1'b1;
        tick(3);

        // normal burst
        drive(0, 1); tick(5);
        drive(0, 0); e = edge_n;
        expect_at("burst_term_en", 5'b10000, e + 6);
        expect_at("burst_hs_rx_en", 5'b11000, e + 26);
        expect_at("burst_clk_active", 5'b11100, e + 27);
        tick(10);
        hs_clk_seen = 1'b1;
        tick(20);

        // clock stop
        hs_clk_seen = 1'b0; e = edge_n;
        expect_at("clk_stop_hs_end", 5'b00000, e + 8);
        tick(12);
        drive(1, 1); tick(6);
        check("pending_after_burst", sb.size(), 0);

        // glitch filter
        drive(0, 1); tick(1);
        drive(1, 1); tick(5);
        drive(0, 0); tick(1);
        drive(1, 1); tick(6);
        check("pending_after_glitch", sb.size(), 0);

        // aborts
        drive(0, 1); tick(5);
        drive(1, 1); tick(6);
        check("pending_after_rqst_abort", sb.size(), 0);
        drive(0, 1); tick(5);
        drive(0, 0); e = edge_n;
        expect_at("settle_abort_term_on", 5'b10000, e + 6);
        expect_at("settle_abort_term_off", 5'b00000, e + 13);
        tick(10);
        drive(1, 1); tick(8);
        check("pending_after_settle_abort", sb.size(), 0);

        // illegal 11-01-10, then ERR must hold through 01 and 00
        drive(0, 1); tick(5);
        drive(1, 0); e = edge_n;
        expect_at("illegal_err_rise", 5'b00010, e + 3);
        expect_at("illegal_err_fall", 5'b00000, e + 4);
        tick(6);
        drive(0, 1); tick(5);
        drive(0, 0); tick(10);
        drive(1, 1); tick(6);
        check("pending_after_illegal", sb.size(), 0);

        // burst with no clock
        drive(0, 1); tick(5);
        drive(0, 0); e = edge_n;
        expect_at("noclk_term_en", 5'b10000, e + 6);
        expect_at("noclk_hs_rx_en", 5'b11000, e + 26);
        expect_at("noclk_err_rise", 5'b00010, e + 34);
        expect_at("noclk_err_fall", 5'b00000, e + 35);
        tick(40);
        drive(1, 1); tick(6);
        check("pending_after_noclk", sb.size(), 0);

        // ULPS entry/exit, or error when the feature is absent
        drive(1, 0); e = edge_n;
`ifdef CLK_ULPS_EN
        expect_at("ulps_enter", 5'b00001, e + 8);
        expect_at("ulps_exit", 5'b00000, e + 18);
`else
        expect_at("lp10_err_rise", 5'b00010, e + 3);
        expect_at("lp10_err_fall", 5'b00000, e + 4);
`endif
        tick(5);
        drive(0, 0); tick(5);
        drive(1, 0); tick(5);
        drive(1, 1); tick(8);
        check("pending_after_ulps", sb.size(), 0);

        // reset in the middle of HS_CLK
        drive(0, 1); tick(5);
        drive(0, 0); e = edge_n;
        expect_at("rst_burst_term_en", 5'b10000, e + 6);
        expect_at("rst_burst_hs_rx_en", 5'b11000, e + 26);
        expect_at("rst_burst_clk_active", 5'b11100, e + 27);
        tick(10);
        hs_clk_seen = 1'b1;
        tick(20);
        expect_at("rst_drop", 5'b00000, edge_n);
        rst_n = 1'b0;
        #1;
        check("reset_async_outputs", int'(outv), 0);
        hs_clk_seen = 1'b0;
        drive(1, 1); tick(2);
        rst_n = 1'b1;
        tick(4);
        drive(0, 0); e = edge_n;
        expect_at("post_rst_stop_err_rise", 5'b00010, e + 3);
        expect_at("post_rst_stop_err_fall", 5'b00000, e + 4);
        tick(8);
        drive(1, 1); tick(6);
        check("pending_final", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
